// File: rtl/mem_seq.sv
// Multi-word memory read sequencer: gathers up to three instruction words and one
// operand word through a single fixed-latency memory port, plus single-cycle writes.
module mem_seq #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem1RE,
  input  logic          mem2RE,
  input  logic          mem3RE,
  input  logic          mem4RE,
  input  logic          memWE,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] opAddr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] word1,
  output logic [DW-1:0] word2,
  output logic [DW-1:0] word3,
  output logic [DW-1:0] word4,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t        state_q;
  logic [3:0]    pend_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] op_q;
  logic [1:0]    cnt_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] word_q [4];

  logic [3:0]    req;
  logic [1:0]    sel_d;
  logic [3:0]    pend_d;
  logic [AW-1:0] issue_addr;

  assign req = {mem4RE, mem3RE, mem2RE, mem1RE};

  // Lowest-numbered pending word wins; the chosen index is held in sel_q through WAIT.
  always_comb begin
    sel_d = 2'd0;
    if (pend_q[0])      sel_d = 2'd0;
    else if (pend_q[1]) sel_d = 2'd1;
    else if (pend_q[2]) sel_d = 2'd2;
    else if (pend_q[3]) sel_d = 2'd3;
  end

  always_comb begin
    issue_addr = op_q;
    case (sel_d)
      2'd0:    issue_addr = pc_q;
      2'd1:    issue_addr = pc_q + AW'(1);
      2'd2:    issue_addr = pc_q + AW'(2);
      default: issue_addr = op_q;
    endcase
  end

  assign pend_d = pend_q & ~(4'b0001 << sel_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 4'b0;
      pc_q    <= '0;
      op_q    <= '0;
      cnt_q   <= 2'd0;
      sel_q   <= 2'd0;
      for (int i = 0; i < 4; i++) word_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            pend_q  <= req;
            pc_q    <= pc;
            op_q    <= opAddr;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          sel_q   <= sel_d;
          cnt_q   <= CNT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            word_q[sel_q] <= mem_rdata;
            pend_q        <= pend_d;
            state_q       <= (|pend_d) ? ISSUE : DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // stall is gated by rst so it drops immediately when a transaction is aborted,
  // even though the requester is still holding its read requests.
  always_comb begin
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = opAddr;
    mem_wdata = wdata;
    if (rst) begin
      case (state_q)
        IDLE: begin
          stall  = |req;
          mem_we = memWE;
        end
        ISSUE: begin
          stall    = 1'b1;
          mem_re   = 1'b1;
          mem_addr = issue_addr;
        end
        WAIT:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign word1 = word_q[0];
  assign word2 = word_q[1];
  assign word3 = word_q[2];
  assign word4 = word_q[3];

endmodule

// File: tb/tb_mem_seq.sv
// Randomized scoreboard bench for mem_seq: stimulus pushes expected transactions,
// a monitor pops and compares at the end of each stall burst.
module tb_mem_seq;

  localparam int TB_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem1RE, mem2RE, mem3RE, mem4RE, memWE;
  logic [7:0]  pc, opAddr;
  logic [15:0] wdata;
  logic        stall;
  logic [15:0] word1, word2, word3, word4;
  logic [7:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [3:0][7:0]  a;
    logic [7:0]       n;
    logic [7:0]       stall_cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  logic [15:0] ref_words [4];
  logic [15:0] pipe [TB_LAT];

  mem_seq #(.AW(8), .DW(16), .LAT(TB_LAT)) dut (
    .clk(clk), .rst(rst),
    .mem1RE(mem1RE), .mem2RE(mem2RE), .mem3RE(mem3RE), .mem4RE(mem4RE),
    .memWE(memWE), .pc(pc), .opAddr(opAddr), .wdata(wdata),
    .stall(stall), .word1(word1), .word2(word2), .word3(word3), .word4(word4),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // External memory: reads return data exactly TB_LAT cycles after mem_re, garbage otherwise.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem_re ? mem[mem_addr] : 16'hDEAD;
    for (int i = TB_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[TB_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: counts stall cycles and issued addresses; a falling stall closes a transaction.
  initial begin
    int scnt;
    int nre;
    logic [3:0][7:0] got_a;
    exp_t e;
    scnt = 0; nre = 0; got_a = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        scnt = 0; nre = 0;
      end else begin
        if (mem_re) begin
          if (nre < 4) got_a[nre] = mem_addr;
          nre++;
        end
        if (stall) scnt++;
        else if (scnt > 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", 32'(scnt), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("stall_cycles", 32'(scnt), 32'(e.stall_cycles));
            chk("num_reads", 32'(nre), 32'(e.n));
            for (int k = 0; k < 4; k++)
              if (k < int'(e.n)) chk("read_addr", 32'(got_a[k]), 32'(e.a[k]));
            chk("word1", 32'(word1), 32'(e.w[0]));
            chk("word2", 32'(word2), 32'(e.w[1]));
            chk("word3", 32'(word3), 32'(e.w[2]));
            chk("word4", 32'(word4), 32'(e.w[3]));
            $display("txn done: reads=%0d stall=%0d words=%h %h %h %h",
                     nre, scnt, word1, word2, word3, word4);
          end
          scnt = 0; nre = 0;
        end
      end
    end
  end

  // Reference: word n of a request reads pc+n-1 (wrapping) or opAddr, in ascending order.
  task automatic push_expected(input logic [3:0] mask, input logic [7:0] p, input logic [7:0] op);
    exp_t e;
    int k;
    logic [7:0] addr;
    e = '0; k = 0;
    for (int n = 0; n < 4; n++) begin
      if (mask[n]) begin
        addr = (n < 3) ? 8'(p + 8'(n)) : op;
        ref_words[n] = ref_mem[addr];
        e.a[k] = addr;
        k++;
      end
    end
    for (int n = 0; n < 4; n++) e.w[n] = ref_words[n];
    e.n = 8'(k);
    e.stall_cycles = 8'(1 + k * (TB_LAT + 1));
    exp_q.push_back(e);
  endtask

  task automatic drive_re(input logic [3:0] mask);
    {mem4RE, mem3RE, mem2RE, mem1RE} = mask;
  endtask

  // Requester behaviour: hold requests while stalled, scramble pc/opAddr and poke memWE.
  task automatic wait_done();
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      memWE = 1'b0;
      cyc++;
      if (cyc > 200) begin
        chk("timeout", 32'(cyc), 32'd0);
        drive_re(4'b0);
        return;
      end
      if (!stall) begin
        drive_re(4'b0);
        return;
      end
      pc     = 8'($urandom);
      opAddr = 8'($urandom);
      wdata  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        memWE = 1'b1;
        #1 chk("we_ignored", 32'(mem_we), 32'd0);
      end
    end
  endtask

  task automatic do_read(input logic [3:0] mask, input logic [7:0] p, input logic [7:0] op,
                         input logic we, input logic [15:0] wd);
    @(negedge clk);
    drive_re(mask);
    pc = p; opAddr = op; memWE = we; wdata = wd;
    if (we) ref_mem[op] = wd;
    push_expected(mask, p, op);
    if (we) begin
      #1;
      chk("rw_mem_we", 32'(mem_we), 32'd1);
      chk("rw_mem_addr", 32'(mem_addr), 32'(op));
      chk("rw_mem_wdata", 32'(mem_wdata), 32'(wd));
    end
    wait_done();
  endtask

  task automatic do_write(input logic [7:0] op, input logic [15:0] wd);
    @(negedge clk);
    memWE = 1'b1; opAddr = op; wdata = wd;
    ref_mem[op] = wd;
    #1;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'(op));
    chk("wr_mem_wdata", 32'(mem_wdata), 32'(wd));
    chk("wr_stall", 32'(stall), 32'd0);
    $display("write addr=%h data=%h", op, wd);
    @(negedge clk);
    memWE = 1'b0;
    #1 chk("wr_stall_after", 32'(stall), 32'd0);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    drive_re(4'b0111);
    pc = 8'h30; opAddr = 8'h77; memWE = 1'b0;
    push_expected(4'b0111, 8'h30, 8'h77);
    repeat (TB_LAT + 3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_word1", 32'(word1), 32'd0);
    chk("rst_word2", 32'(word2), 32'd0);
    chk("rst_word3", 32'(word3), 32'd0);
    chk("rst_word4", 32'(word4), 32'd0);
    $display("reset asserted during word2 wait");
    exp_q.delete();
    for (int n = 0; n < 4; n++) ref_words[n] = 16'h0;
    @(negedge clk);
    rst = 1'b1;
    push_expected(4'b0111, 8'h30, 8'h77);
    wait_done();
  endtask

  initial begin
    logic [3:0]  mask;
    logic        we;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < TB_LAT; i++) pipe[i] = 16'h0;
    for (int n = 0; n < 4; n++) ref_words[n] = 16'h0;
    rst = 1'b0;
    drive_re(4'b0001);
    memWE = 1'b0; pc = 8'h00; opAddr = 8'h00; wdata = 16'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mem_re", 32'(mem_re), 32'd0);
    chk("reset_words", 32'({word1, word2} | {word3, word4}), 32'd0);
    @(negedge clk);
    drive_re(4'b0);
    rst = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      opAddr = 8'($urandom);
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_mem_re", 32'(mem_re), 32'd0);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
    end

    mem[8'h10] = 16'h00A1; ref_mem[8'h10] = 16'h00A1;
    mem[8'h11] = 16'h00B2; ref_mem[8'h11] = 16'h00B2;
    mem[8'h12] = 16'h00C3; ref_mem[8'h12] = 16'h00C3;
    do_read(4'b0111, 8'h10, 8'h55, 1'b0, 16'h0);
    do_read(4'b0111, 8'hFF, 8'h55, 1'b0, 16'h0);
    mem[8'h40] = 16'h1234; ref_mem[8'h40] = 16'h1234;
    do_read(4'b1000, 8'h00, 8'h40, 1'b0, 16'h0);
    do_write(8'h20, 16'hBEEF);
    do_read(4'b1000, 8'h90, 8'h20, 1'b0, 16'h0);
    do_read(4'b1010, 8'h20, 8'h21, 1'b1, 16'h5A5A);
    reset_mid_wait();

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_write(8'($urandom), 16'($urandom));
      end else begin
        mask = 4'($urandom_range(1, 15));
        we   = ($urandom_range(0, 3) == 0);
        do_read(mask, 8'($urandom), 8'($urandom), we, 16'($urandom));
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
